// File: rtl/vco_pkg.sv
// vco_pkg: shared types and helpers for the wavetable VCO voice scheduler.
//   state_t   : scheduler FSM encoding (explicit, legacy-compatible values)
//   PHASE_W   : phase accumulator width
//   LUT_SHIFT : V/Oct input to LUT index right shift (arithmetic)
//   lut_clamp : signed V/Oct sample -> clamped LUT word address
//   wt_index  : phase -> wavetable index field
package vco_pkg;

  localparam int PHASE_W   = 32;
  localparam int LUT_SHIFT = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LUT_RD = 3'd1,
    S_LUT_WT = 3'd2,
    S_WT_RD  = 3'd3,
    S_WT_WT  = 3'd4,
    S_WT2_RD = 3'd5,
    S_WT2_WT = 3'd6,
    S_COMMIT = 3'd7
  } state_t;

  // Input is the sample sign-extended to 32 bits by the caller.
  function automatic logic [31:0] lut_clamp(input logic signed [31:0] v,
                                            input int lut_size);
    logic signed [31:0] s;
    s = v >>> LUT_SHIFT;
    if (s < 0)         return '0;
    if (s >= lut_size) return 32'(lut_size - 1);
    return s;
  endfunction

  function automatic logic [31:0] wt_index(input logic [PHASE_W-1:0] phase,
                                           input int bit_start,
                                           input int wt_bits);
    return (phase >> bit_start) & ((32'd1 << wt_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/vco_phase_bank.sv
// vco_phase_bank: NV x PW phase registers, one write port, one read port.
//   clk, rst_n  : clock, async active-low clear of all phases
//   wr_en/idx/data : write port (voice index)
//   rd_idx/rd_data : combinational read port (voice index)
module vco_phase_bank #(
  parameter int NV = 4,
  parameter int PW = 32,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [PW-1:0] wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [PW-1:0] rd_data
);

  logic [NV-1:0][PW-1:0] ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
    end else begin
      for (int i = 0; i < NV; i++)
        if (wr_en && wr_idx == IW'(i)) ph[i] <= wr_data;
    end
  end

  assign rd_data = ph[rd_idx];

endmodule

// File: rtl/vco_voice_scheduler.sv
// vco_voice_scheduler: shares one single-port ROM among NUM_VOICES 1V/Oct
// wavetable oscillators. Each sample_clk rising edge runs one frame: for each
// voice, LUT read -> phase accumulate -> wavetable read, then all outputs
// commit together.
//   clk, rst_n   : system clock, async active-low reset
//   sample_clk   : codec sample-rate level (synchronised here)
//   sample_in    : NV x W signed V/Oct inputs, voice v at [v*W +: W]
//   mem_rd_en/mem_addr/mem_rdata : ROM port, data 1 clk after strobe
//   sample_out   : NV x W registered voice outputs
//   busy         : frame in progress
//   frame_done   : 1-clk pulse in the commit cycle
//   overrun      : sticky, sample edge seen while not idle
// Optional macro VCO_SCHED_INTERP_EN: linear interpolation between adjacent
// wavetable entries (extra WT2_RD/WT2_WT per voice, 6 clk/voice).
module vco_voice_scheduler
  import vco_pkg::*;
#(
  parameter int W          = 16,
  parameter int NUM_VOICES = 4,
  parameter int LUT_SIZE   = 512,
  parameter int WT_SIZE    = 256,
  parameter int WT_BASE    = 512,
  parameter int BIT_START  = 10,
  parameter int AW         = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_clk,
  input  logic [NUM_VOICES*W-1:0] sample_in,
  output logic                    mem_rd_en,
  output logic [AW-1:0]           mem_addr,
  input  logic [W-1:0]            mem_rdata,
  output logic [NUM_VOICES*W-1:0] sample_out,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int NV      = NUM_VOICES;
  localparam int VW      = (NV > 1) ? $clog2(NV) : 1;
  localparam int WT_BITS = $clog2(WT_SIZE);

  logic                  sc_s1, sc_s2, sc_s3, edge_det;
  state_t                state;
  logic [VW-1:0]         v;
  logic                  last_voice;
  logic [NV-1:0][W-1:0]  snap, staged, out_q;
  logic [AW-1:0]         mem_addr_q;
  logic                  overrun_q;

  logic [PHASE_W-1:0]    ph_rd, ph_wr;
  logic                  ph_we;
  logic signed [W-1:0]   cur_in;
  logic [AW-1:0]         lut_addr, wt_addr;
  logic [WT_BITS-1:0]    wt_idx;

  assign edge_det   = sc_s2 & ~sc_s3;
  assign last_voice = (v == VW'(NV - 1));

  assign cur_in   = snap[v];
  assign lut_addr = AW'(lut_clamp({{(32-W){cur_in[W-1]}}, cur_in}, LUT_SIZE));
  // ph_rd already holds the accumulated phase by the time WT_RD runs.
  assign wt_idx   = WT_BITS'(wt_index(ph_rd, BIT_START, WT_BITS));
  assign wt_addr  = AW'(WT_BASE) + AW'(wt_idx);

  assign ph_we = (state == S_LUT_WT);
  assign ph_wr = ph_rd + PHASE_W'(mem_rdata);

  vco_phase_bank #(.NV(NV), .PW(PHASE_W), .IW(VW)) u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ph_we),
    .wr_idx  (v),
    .wr_data (ph_wr),
    .rd_idx  (v),
    .rd_data (ph_rd)
  );

`ifdef VCO_SCHED_INTERP_EN
  logic [W-1:0]         wt_a;
  logic [WT_BITS-1:0]   wt_idx2;
  logic [AW-1:0]        wt2_addr;
  logic [7:0]           frac;
  logic signed [W+8:0]  a_x, b_x, f_x, diff, prod;
  logic [W-1:0]         interp_out;

  assign wt_idx2    = wt_idx + WT_BITS'(1);  // wraps mod WT_SIZE
  assign wt2_addr   = AW'(WT_BASE) + AW'(wt_idx2);
  assign frac       = ph_rd[BIT_START-1 -: 8];
  assign a_x        = {{9{wt_a[W-1]}}, wt_a};
  assign b_x        = {{9{mem_rdata[W-1]}}, mem_rdata};
  assign f_x        = {{(W+1){1'b0}}, frac};
  assign diff       = b_x - a_x;
  assign prod       = diff * f_x;
  assign interp_out = W'(a_x + (prod >>> 8));
`endif

  assign mem_rd_en = (state == S_LUT_RD) || (state == S_WT_RD) || (state == S_WT2_RD);

  // Address is only driven fresh in read states; otherwise it parks.
  always_comb begin
    mem_addr = mem_addr_q;
    case (state)
      S_LUT_RD: mem_addr = lut_addr;
      S_WT_RD:  mem_addr = wt_addr;
`ifdef VCO_SCHED_INTERP_EN
      S_WT2_RD: mem_addr = wt2_addr;
`endif
      default:  mem_addr = mem_addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_s1      <= 1'b0;
      sc_s2      <= 1'b0;
      sc_s3      <= 1'b0;
      state      <= S_IDLE;
      v          <= '0;
      snap       <= '0;
      staged     <= '0;
      out_q      <= '0;
      mem_addr_q <= '0;
      overrun_q  <= 1'b0;
`ifdef VCO_SCHED_INTERP_EN
      wt_a       <= '0;
`endif
    end else begin
      sc_s1      <= sample_clk;
      sc_s2      <= sc_s1;
      sc_s3      <= sc_s2;
      mem_addr_q <= mem_addr;
      // Edges outside IDLE (COMMIT included) are dropped and flagged.
      if (edge_det && state != S_IDLE) overrun_q <= 1'b1;

      case (state)
        S_IDLE: if (edge_det) begin
          snap  <= sample_in;
          v     <= '0;
          state <= S_LUT_RD;
        end
        S_LUT_RD: state <= S_LUT_WT;
        S_LUT_WT: state <= S_WT_RD;
        S_WT_RD:  state <= S_WT_WT;
`ifdef VCO_SCHED_INTERP_EN
        S_WT_WT: begin
          wt_a  <= mem_rdata;
          state <= S_WT2_RD;
        end
        S_WT2_RD: state <= S_WT2_WT;
        S_WT2_WT: begin
          staged[v] <= interp_out;
          if (last_voice) state <= S_COMMIT;
          else begin
            v     <= v + VW'(1);
            state <= S_LUT_RD;
          end
        end
`else
        S_WT_WT: begin
          staged[v] <= mem_rdata;
          if (last_voice) state <= S_COMMIT;
          else begin
            v     <= v + VW'(1);
            state <= S_LUT_RD;
          end
        end
`endif
        S_COMMIT: begin
          out_q <= staged;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sample_out = out_q;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_COMMIT);
  assign overrun    = overrun_q;

endmodule
